// File: rtl/serial_add4_seq.sv
// serial_add4_seq: bit-serial four-operand adder sequencer.
// Accepts four N-bit operands, sums one bit column per cycle
// LSB-first and hands off the (N+2)-bit total on valid/ready.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   in_valid/ready  operand handshake (a, b, c, d)
//   out_valid/ready result handshake (result)
//   busy            high in RUN or DONE
// Optional macro SERIAL_ADD4_STREAM_EN adds bit_out/bit_valid,
// a serial copy of each column's sum bit.
module serial_add4_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [N-1:0] d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N+1:0] result,
`ifdef SERIAL_ADD4_STREAM_EN
   output logic         bit_out,
   output logic         bit_valid,
`endif
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_sr_q, a_sr_d;
   logic [N-1:0]   b_sr_q, b_sr_d;
   logic [N-1:0]   c_sr_q, c_sr_d;
   logic [N-1:0]   d_sr_q, d_sr_d;
   logic [1:0]     carry_q, carry_d;
   logic [4:0]     col_q, col_d;
   logic [N+1:0]   res_q, res_d;
   logic [2:0]     fa;
   logic [2:0]     s;
   logic           last_col;

   // 4-input full adder {C2,C1,sum}; shift registers are
   // zero-filled, so the flush columns see bits=0 for free.
   assign fa = 3'(a_sr_q[0]) + 3'(b_sr_q[0])
             + 3'(c_sr_q[0]) + 3'(d_sr_q[0]);
   assign s  = fa + {1'b0, carry_q};
   assign last_col = (col_q == 5'(N + 1));

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      c_sr_d  = c_sr_q;
      d_sr_d  = d_sr_q;
      carry_d = carry_q;
      col_d   = col_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               c_sr_d  = c;
               d_sr_d  = d;
               carry_d = 2'd0;
               col_d   = 5'd0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = res_q | ((N+2)'(s[0]) << col_q);
            carry_d = s[2:1];
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            c_sr_d  = c_sr_q >> 1;
            d_sr_d  = d_sr_q >> 1;
            col_d   = col_q + 5'd1;
            if (last_col) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         c_sr_q  <= '0;
         d_sr_q  <= '0;
         carry_q <= 2'd0;
         col_q   <= 5'd0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         c_sr_q  <= c_sr_d;
         d_sr_q  <= d_sr_d;
         carry_q <= carry_d;
         col_q   <= col_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign result    = res_q;

`ifdef SERIAL_ADD4_STREAM_EN
   logic bit_out_q, bit_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
      end else begin
         bit_valid_q <= (state_q == RUN);
         bit_out_q   <= (state_q == RUN) ? s[0] : 1'b0;
      end
   end

   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
`endif

   // 4*(2^N-1) < 2^(N+2): nothing may carry out of the top column.
   a_final_carry: assert property (
      @(posedge clk) disable iff (rst)
      (state_q == RUN && last_col) |-> (s[2:1] == 2'd0)
   );

endmodule

// File: tb/tb_serial_add4_seq.sv
// tb_serial_add4_seq: randomized self-checking bench for
// serial_add4_seq against a plain-arithmetic sum model.
module tb_serial_add4_seq;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic [N-1:0] c = '0;
   logic [N-1:0] d = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N+1:0] result;
   logic         busy;
`ifdef SERIAL_ADD4_STREAM_EN
   logic         bit_out;
   logic         bit_valid;
`endif

   int checks = 0;
   int errors = 0;

   serial_add4_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef SERIAL_ADD4_STREAM_EN
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got,
                      input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic scramble();
      a = N'($urandom);
      b = N'($urandom);
      c = N'($urandom);
      d = N'($urandom);
   endtask

   // One transaction: accept, time the run, check the sum,
   // hold DONE for 'hold' cycles under noise, then hand off.
   task automatic txn(input logic [N-1:0] ta, input logic [N-1:0] tb,
                      input logic [N-1:0] tc, input logic [N-1:0] td,
                      input int hold);
      int n;
      int exp;
      exp = int'(ta) + int'(tb) + int'(tc) + int'(td);
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("in_ready_idle", int'(in_ready), 1);
      a = ta; b = tb; c = tc; d = td;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
      chk("busy_run", int'(busy), 1);
      chk("in_ready_run", int'(in_ready), 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", n, N + 2);
      chk("sum", int'(result), exp);
      repeat (hold) begin
         in_valid = 1'b1;
         scramble();
         @(posedge clk); #1;
         chk("hold_sum", int'(result), exp);
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_valid", int'(out_valid), 0);
      chk("handoff_ready", int'(in_ready), 1);
      chk("handoff_busy", int'(busy), 0);
      chk("handoff_result", int'(result), exp);
   endtask

   initial begin
      rst = 1'b1;
      #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result", int'(result), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      txn(4'd0, 4'd0, 4'd0, 4'd0, 1);
      txn(4'd1, 4'd2, 4'd3, 4'd4, 0);
      txn(4'hF, 4'hF, 4'hF, 4'hF, 0);

      for (int i = 0; i < 16; i++) begin
         txn(N'(i & 1), N'((i >> 1) & 1),
             N'((i >> 2) & 1), N'((i >> 3) & 1), 0);
      end

      txn(4'd9, 4'd5, 4'd14, 4'd3, 10);
      txn(4'd2, 4'd11, 4'd6, 4'd13, 0);

      // Abort mid-run: column 2 reached, reset between edges.
      a = 4'hA; b = 4'h5; c = 4'hC; d = 4'h3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_result", int'(result), 0);
      #1;
      rst = 1'b0;
      txn(4'd7, 4'd7, 4'd7, 4'd7, 0);

      for (int i = 0; i < 25; i++) begin
         txn(N'($urandom), N'($urandom), N'($urandom),
             N'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_add4_seq.md
Name: serial_add4_seq

Overview:
- Bit-serial sequencer around the 4-input full-adder datapath (column sum of four bits → sum, C1, C2).
- Accepts four N-bit unsigned operands, feeds one bit column per cycle LSB-first, and holds the running carry.
- Assembles the (N+2)-bit total and hands it off on a valid/ready handshake.
- Sits between the operand source and any consumer needing a 4-operand sum without a parallel adder tree.

Parameters:
N, 4, operand width in bits; legal range 1..16; result width is N+2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set a/b/c/d valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  operand A
b  input  N  operand B
c  input  N  operand C
d  input  N  operand D
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
result  output  N+2  a+b+c+d, unsigned
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; internal carry, column counter and shift registers cleared. Reset mid-RUN or mid-DONE aborts immediately, and the in-flight sum is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch a, b, c and d into shift registers, clear carry (2 bits) and col (counter), clear the result accumulator, and go to RUN. Operand inputs are ignored at all other times.
- RUN: in_ready=0, busy=1. Each edge processes one column k=col:
  - bits = a_sr[0]+b_sr[0]+c_sr[0]+d_sr[0] for k<N; bits=0 for k=N and k=N+1 (carry flush).
  - s = bits + carry, range 0..7, 3 bits wide.
  - result bit k = s[0]; carry = s[2:1]; shift registers shift right with zero fill; col increments.
  - The column adder is the 4-input full adder {C2,C1,sum}; adding the carry is a 2-bit add into that 3-bit value.
  - After the edge that processes k=N+1, go to DONE.
- RUN takes exactly N+2 edges. out_valid first reads 1 after the (N+2)th edge following the accepting edge.
- Final carry is always 0, because 4·(2^N−1) < 2^(N+2). Implementation carries an assertion on this.
- DONE: out_valid=1; result is stable and holds its value. On an edge with out_ready=1, go to IDLE: out_valid→0, in_ready→1, and result holds its last value until the next accept.
- Accept and hand-off never overlap, because in_ready=0 in DONE. Minimum spacing between accepts is N+3 edges.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored, and the source must hold it.
- result bits above the current column read 0 during RUN. The consumer samples result only when out_valid=1.

Optional Feature:
- Macro SERIAL_ADD4_STREAM_EN.
- Defined: adds output ports bit_out (1) and bit_valid (1).
  - bit_valid=1 for exactly the N+2 cycles following each RUN column edge.
  - bit_out = s[0] of the column just processed, LSB first, which allows serial downstream use before DONE.
  - Both ports are 0 at reset and outside those cycles.
- Not defined: the ports are absent, and the parallel behaviour is identical in both builds.

Test Plan:
- N=4, rst pulse then a=b=c=d=0, in_valid 1 cycle → out_valid after 6 edges; result=6'd0; in_ready low for 7 cycles total (6 RUN + ≥1 DONE).
- N=4, a=1, b=2, c=3, d=4, out_ready tied 1 → result=6'd10; out_valid high exactly 1 cycle; in_ready returns 1 the following cycle.
- N=4, a=b=c=d=4'hF → result=6'd60 (6'b111100); final carry 0.
- N=4, exhaustive 1-bit sweep: a,b,c,d ∈ {0,1} in all 16 combos via N=1 build → result = popcount (0..4); 3 edges per RUN.
- Backpressure: result pending, out_ready=0 for 10 cycles, new in_valid with different operands → result unchanged, in_ready=0; then out_ready=1 → IDLE, and the second operand set is accepted the next edge.
- Async reset asserted at RUN column 2 between clock edges → outputs reset immediately with no clock; after release, a fresh 7+7+7+7 → result=6'd28.
